// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package anim_pkg;

    typedef enum logic [1:0] {IDLE, ATK, PUN, DEAD} anim_state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_ATK, REQ_PUN, REQ_DEAD} key_req_t;

    localparam logic [7:0] KEY_W   = 8'h1A;
    localparam logic [7:0] KEY_S   = 8'h16;
    localparam logic [7:0] KEY_ESC = 8'h29;

    localparam logic [7:0] SPR_IDLE = 8'h00;
    localparam logic [7:0] SPR_ATK  = 8'h10;
    localparam logic [7:0] SPR_PUN  = 8'h18;
    localparam logic [7:0] SPR_DEAD = 8'h20;

    function automatic key_req_t decode_key(input logic [7:0] key);
        case (key)
            KEY_W:   return REQ_ATK;
            KEY_S:   return REQ_PUN;
            KEY_ESC: return REQ_DEAD;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Synchronises an active-low async strobe (vs/hs) into clk and emits a
// registered one-cycle pulse on each falling edge.
module vs_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sig_n,
    output logic pulse
);

    logic s1, s2, s3;
    logic fill1, fill2, armed;

    // The sync flops reset high, so a line held low across reset would look
    // like a fall; pulses are only allowed once a genuine high has been seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= sig_n;
            s2    <= s1;
            s3    <= s2;
            fill1 <= 1'b1;
            fill2 <= fill1;
            armed <= armed | (fill2 & s2);
            pulse <= armed & s3 & ~s2;
        end
    end

endmodule

// File: rtl/sprite_anim_seq.sv
// Frame-rate character animation sequencer: idle loop, one-shot attack and
// punch sequences, terminal dead pose; steps once every HOLD_FRAMES frames.
module sprite_anim_seq
    import anim_pkg::*;
#(
    parameter int HOLD_FRAMES = 4,
    parameter int IDLE_LEN    = 5,
    parameter int ATK_LEN     = 4,
    parameter int PUN_LEN     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vs,
    input  logic [7:0] keycode,
    output logic [7:0] Sprite,
    output logic       frame_tick,
    output logic       busy
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_FRAMES - 1);
    localparam logic [3:0] IDLE_LAST = 4'(IDLE_LEN - 1);
    localparam logic [3:0] ATK_LAST  = 4'(ATK_LEN - 1);
    localparam logic [3:0] PUN_LAST  = 4'(PUN_LEN - 1);

    anim_state_t state, nxt_state;
    logic [3:0]  step, nxt_step;
    logic [3:0]  hold_cnt;
    logic        advance;
    key_req_t    req;

    function automatic logic [7:0] sprite_for(input anim_state_t s, input logic [3:0] st);
        case (s)
            IDLE:    return SPR_IDLE + {4'd0, st};
            ATK:     return SPR_ATK + {4'd0, st};
            PUN:     return SPR_PUN + {4'd0, st};
            default: return SPR_DEAD;
        endcase
    endfunction

    vs_edge_sync u_vs_sync (
        .clk   (Clk),
        .reset (Reset),
        .sig_n (vs),
        .pulse (frame_tick)
    );

    assign advance = frame_tick && (hold_cnt == HOLD_LAST);

    always_comb begin
        req       = decode_key(keycode);
        nxt_state = state;
        nxt_step  = step;
        if (advance) begin
            case (state)
                IDLE: begin
                    case (req)
                        REQ_ATK:  begin nxt_state = ATK; nxt_step = '0; end
                        REQ_PUN:  begin nxt_state = PUN; nxt_step = '0; end
                        REQ_DEAD: begin nxt_state = DEAD; nxt_step = '0; end
                        default:  nxt_step = (step == IDLE_LAST) ? 4'd0 : step + 4'd1;
                    endcase
                end
                ATK: begin
                    if (req == REQ_DEAD) begin
                        nxt_state = DEAD;
                        nxt_step  = '0;
                    end else if (step == ATK_LAST) begin
                        nxt_state = IDLE;
                        nxt_step  = '0;
                    end else begin
                        nxt_step = step + 4'd1;
                    end
                end
                PUN: begin
                    if (req == REQ_DEAD) begin
                        nxt_state = DEAD;
                        nxt_step  = '0;
                    end else if (step == PUN_LAST) begin
                        nxt_state = IDLE;
                        nxt_step  = '0;
                    end else begin
                        nxt_step = step + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are derived from the next state so they land on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            step     <= '0;
            hold_cnt <= '0;
            Sprite   <= SPR_IDLE;
            busy     <= 1'b0;
        end else begin
            state  <= nxt_state;
            step   <= nxt_step;
            Sprite <= sprite_for(nxt_state, nxt_step);
            busy   <= (nxt_state == ATK) || (nxt_state == PUN);
            if (frame_tick)
                hold_cnt <= (hold_cnt == HOLD_LAST) ? 4'd0 : hold_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq; frames are shortened to 40 Clk.
module tb_sprite_anim_seq;

    localparam int FRAME = 40;
    localparam int LOW   = 5;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       vs;
    logic [7:0] keycode;
    logic [7:0] Sprite;
    logic       frame_tick;
    logic       busy;

    int errors = 0;
    int checks = 0;

    sprite_anim_seq #(
        .HOLD_FRAMES (4),
        .IDLE_LEN    (5),
        .ATK_LEN     (4),
        .PUN_LEN     (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .keycode    (keycode),
        .Sprite     (Sprite),
        .frame_tick (frame_tick),
        .busy       (busy)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One vs frame: low for LOW Clk, then high; optionally checks the tick.
    task automatic frame(input bit chk);
        int ticks;
        int pos;
        ticks = 0;
        pos   = -1;
        vs    = 1'b0;
        for (int i = 1; i <= FRAME; i++) begin
            cyc(1);
            if (frame_tick) begin
                ticks++;
                if (pos < 0) pos = i;
            end
            if (i == LOW) vs = 1'b1;
        end
        if (chk) begin
            check("tick_width", ticks, 1);
            check("tick_latency", pos, 3);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) frame(1'b0);
    endtask

    task automatic expect_out(input string tag, input int spr, input int bz);
        check({tag, "_sprite"}, int'(Sprite), spr);
        check({tag, "_busy"}, int'(busy), bz);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] junk [5];
        junk[0] = 8'h1A; junk[1] = 8'h16; junk[2] = 8'h00; junk[3] = 8'h29; junk[4] = 8'hFF;

        Reset = 1'b1; vs = 1'b1; keycode = 8'h00;
        cyc(3);
        expect_out("reset", 'h00, 0);
        check("reset_tick", int'(frame_tick), 0);
        Reset = 1'b0;
        cyc(5);

        // Idle loop 01..04,00,01, advancing every 4th tick
        for (int g = 0; g < 6; g++) begin
            frame(1'b1); frame(1'b1);
            check("t1_hold", int'(Sprite), g % 5);
            frame(1'b1); frame(1'b1);
            expect_out("t1_step", (g + 1) % 5, 0);
        end

        // Attack, key released after the trigger
        keycode = 8'h1A; frames(4); expect_out("t2_a0", 'h10, 1);
        keycode = 8'h00; frames(4); expect_out("t2_a1", 'h11, 1);
        frames(4); expect_out("t2_a2", 'h12, 1);
        frames(4); expect_out("t2_a3", 'h13, 1);
        frames(4); expect_out("t2_idle", 'h00, 0);

        // Punch ignored during attack, then ESC -> dead forever
        keycode = 8'h1A; frames(4); expect_out("t3_a0", 'h10, 1);
        keycode = 8'h00; frames(4); expect_out("t3_a1", 'h11, 1);
        keycode = 8'h16; frames(4); expect_out("t3_a2", 'h12, 1);
        frames(4); expect_out("t3_a3", 'h13, 1);
        keycode = 8'h00; frames(4); expect_out("t3_idle", 'h00, 0);
        keycode = 8'h29; frames(4); expect_out("t3_dead", 'h20, 0);
        for (int k = 0; k < 5; k++) begin
            keycode = junk[k];
            frames(4);
            expect_out("t3_dead_hold", 'h20, 0);
        end
        keycode = 8'h00;

        // Reset mid-punch clears state and hold counter
        Reset = 1'b1; cyc(1); Reset = 1'b0;
        expect_out("t4_rst0", 'h00, 0);
        cyc(4);
        keycode = 8'h16; frames(4); expect_out("t4_p0", 'h18, 1);
        keycode = 8'h00; frames(4); expect_out("t4_p1", 'h19, 1);
        frames(4); expect_out("t4_p2", 'h1A, 1);
        frames(2);
        Reset = 1'b1; cyc(1); Reset = 1'b0;
        expect_out("t4_rst1", 'h00, 0);
        cyc(4);
        frames(3); expect_out("t4_noadv", 'h00, 0);
        frames(1); expect_out("t4_adv", 'h01, 0);

        // vs low across reset release: no tick until a real fall
        vs = 1'b0; Reset = 1'b1; cyc(3); Reset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) vs = 1'b1;
            cyc(1);
            if (frame_tick) n++;
        end
        check("t5_no_tick", n, 0);
        frame(1'b1);
        expect_out("t5_idle", 'h00, 0);

        // Key pulse between ticks has no effect
        frames(2);
        keycode = 8'h1A; cyc(10); keycode = 8'h00;
        expect_out("t6_mid", 'h00, 0);
        frame(1'b0);
        expect_out("t6_adv", 'h01, 0);

        // Held key retriggers only after returning to idle
        keycode = 8'h1A;
        frames(4); expect_out("t7_a0", 'h10, 1);
        frames(4); expect_out("t7_a1", 'h11, 1);
        frames(4); expect_out("t7_a2", 'h12, 1);
        frames(4); expect_out("t7_a3", 'h13, 1);
        frames(4); expect_out("t7_idle", 'h00, 0);
        frames(4); expect_out("t7_retrig", 'h10, 1);
        keycode = 8'h00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
